// File: rtl/clk_div_gen_pkg.sv
// Shared types for the runtime-programmable clock/tick generator:
// waveform modes, control FSM states and the divisor/duty/mode configuration record.
package clk_div_gen_pkg;

   // Config fields are carried at this width; instantiations must keep WIDTH <= CFG_MAX_W.
   localparam int unsigned CFG_MAX_W = 32;

   typedef enum logic [1:0] {
      MODE_TOGGLE = 2'b00,
      MODE_PULSE  = 2'b01,
      MODE_PWM    = 2'b10,
      MODE_RSVD   = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      PEND = 2'b10
   } state_e;

   typedef struct packed {
      logic [CFG_MAX_W-1:0] div;
      logic [CFG_MAX_W-1:0] duty;
      mode_e                mode;
   } cfg_t;

   function automatic logic [CFG_MAX_W-1:0] fix_div(input logic [CFG_MAX_W-1:0] d);
      return (d == '0) ? CFG_MAX_W'(1) : d;
   endfunction

endpackage

// File: rtl/clk_div_gen_cfg.sv
// Shadow configuration register with valid/ready handshake; copies the shadow
// into the active configuration when the counter logic requests an apply.
module clk_div_gen_cfg
   import clk_div_gen_pkg::*;
#(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned DEFAULT_DIV = 250_000
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_valid_i,
   input  logic [WIDTH-1:0] div_i,
   input  logic [WIDTH-1:0] duty_i,
   input  logic [1:0]       mode_i,
   input  logic             apply_i,
   output logic             load_ready_o,
   output logic             accept_o,
   output logic             pending_o,
   output cfg_t             act_o
);

   cfg_t act_q, act_d;
   cfg_t sh_q, sh_d;
   logic pend_q, pend_d;

   assign load_ready_o = ~pend_q;
   assign accept_o     = load_valid_i & ~pend_q;
   assign pending_o    = pend_q;
   assign act_o        = act_q;

   always_comb begin
      act_d  = act_q;
      sh_d   = sh_q;
      pend_d = pend_q;
      if (accept_o) begin
         sh_d.div  = fix_div(CFG_MAX_W'(div_i));
         sh_d.duty = CFG_MAX_W'(duty_i);
         sh_d.mode = mode_e'(mode_i);
         pend_d    = 1'b1;
      end else if (apply_i && pend_q) begin
         act_d  = sh_q;
         pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         act_q.div  <= fix_div(CFG_MAX_W'(DEFAULT_DIV));
         act_q.duty <= CFG_MAX_W'(DEFAULT_DIV / 2);
         act_q.mode <= MODE_TOGGLE;
         sh_q       <= '0;
         pend_q     <= 1'b0;
      end else begin
         act_q  <= act_d;
         sh_q   <= sh_d;
         pend_q <= pend_d;
      end
   end

endmodule

// File: rtl/clk_div_gen.sv
// Programmable divided-clock / tick / PWM generator with glitch-free config apply.
// Optional period counter output enabled by defining CLK_DIV_GEN_TICK_CNT_EN.
module clk_div_gen
   import clk_div_gen_pkg::*;
#(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned DEFAULT_DIV = 250_000,
   parameter int unsigned TICK_CNT_W  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  load_valid,
   output logic                  load_ready,
   input  logic [WIDTH-1:0]      div_in,
   input  logic [WIDTH-1:0]      duty_in,
   input  logic [1:0]            mode_in,
   output logic                  clk_out,
   output logic                  tick,
   output logic                  busy,
   output logic [WIDTH-1:0]      cnt
`ifdef CLK_DIV_GEN_TICK_CNT_EN
   ,
   output logic [TICK_CNT_W-1:0] tick_cnt
`endif
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             clk_out_q, clk_out_d;
   logic             tick_q, tick_d;

   cfg_t             act;
   logic             accept, pending, apply, apply_idle, wrap;
   logic [WIDTH-1:0] act_div, act_duty, cnt_nxt;

   clk_div_gen_cfg #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
   ) u_cfg (
      .clk_i        (clk),
      .rst_i        (rst),
      .load_valid_i (load_valid),
      .div_i        (div_in),
      .duty_i       (duty_in),
      .mode_i       (mode_in),
      .apply_i      (apply),
      .load_ready_o (load_ready),
      .accept_o     (accept),
      .pending_o    (pending),
      .act_o        (act)
   );

   assign act_div  = act.div[WIDTH-1:0];
   assign act_duty = act.duty[WIDTH-1:0];
   assign wrap     = (cnt_q == act_div - WIDTH'(1));
   assign cnt_nxt  = wrap ? '0 : cnt_q + WIDTH'(1);

   // A pending shadow is applied immediately when stopped (or stopping), else only at a wrap.
   assign apply_idle = pending & ((state_q == IDLE) | ((state_q == PEND) & ~en));
   assign apply      = apply_idle | ((state_q == PEND) & en & wrap);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      clk_out_d = clk_out_q;
      tick_d    = 1'b0;
      if (apply_idle) begin
         state_d   = IDLE;
         cnt_d     = '0;
         clk_out_d = 1'b0;
      end else if ((state_q == IDLE) && accept) begin
         state_d = IDLE;
      end else if (!en) begin
         state_d = IDLE;
      end else begin
         cnt_d  = cnt_nxt;
         tick_d = wrap;
         case (act.mode)
            MODE_PULSE: clk_out_d = wrap;
            MODE_PWM:   clk_out_d = (cnt_nxt < act_duty);
            default:    clk_out_d = wrap ? ~clk_out_q : clk_out_q;
         endcase
         if (state_q == PEND) begin
            if (wrap) state_d = RUN;
         end else if (accept) begin
            state_d = PEND;
         end else begin
            state_d = RUN;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         clk_out_q <= 1'b0;
         tick_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         clk_out_q <= clk_out_d;
         tick_q    <= tick_d;
      end
   end

   assign cnt     = cnt_q;
   assign clk_out = clk_out_q;
   assign tick    = tick_q;
   assign busy    = (state_q != IDLE);

`ifdef CLK_DIV_GEN_TICK_CNT_EN
   logic [TICK_CNT_W-1:0] tick_cnt_q;

   // Counts alongside the tick register so tick_cnt already includes the tick now visible.
   always_ff @(posedge clk) begin
      if (rst)         tick_cnt_q <= '0;
      else if (tick_d) tick_cnt_q <= tick_cnt_q + TICK_CNT_W'(1);
   end

   assign tick_cnt = tick_cnt_q;
`else
   if (TICK_CNT_W == 0) begin : g_no_tick_cnt
   end
`endif

endmodule
